// File: rtl/fft_pkg.sv
// FFT-side types: complex sample layout, frame sink states and magnitude width.
package fft_pkg;

    localparam int unsigned SINK_DW = 16;
    localparam int unsigned MAG_W   = SINK_DW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } sink_state_e;

    typedef struct packed {
        logic signed [SINK_DW-1:0] re;
        logic signed [SINK_DW-1:0] im;
    } complex_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain stream definitions shared by the FFT datapath and its endpoints.
package user_pkg;

    localparam int unsigned BITREV_DW = 32;

    typedef struct packed {
        logic                 valid;
        logic [BITREV_DW-1:0] data;
    } strm_t;

endpackage

// File: rtl/fft_sink_ram.sv
// Frame buffer: one write port, one registered read port returning old data on collision.
module fft_sink_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register samples the array before this edge's write lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_sink.sv
// Captures one natural-order FFT frame into a local buffer and holds it until released.
// Optional peak-bin tracker enabled by defining FFT_SINK_PEAK_EN.
module fft_frame_sink
    import fft_pkg::*;
    import user_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOGN   = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  strm_t               strm_i,
    output logic                ready_o,
    input  logic                start_i,
    input  logic                release_i,
    output logic                busy_o,
    output logic                full_o,
    output logic                frame_done_o,
    output logic [15:0]         frame_cnt_o,
    input  logic                rd_req_i,
    input  logic [LOGN-1:0]     rd_addr_i,
    output logic                rd_valid_o,
    output logic [2*DATA_W-1:0] rd_data_o,
    output logic [DATA_W:0]     peak_mag_o,
    output logic [LOGN-1:0]     peak_idx_o
);

    localparam logic [LOGN-1:0] PTR_ONE = LOGN'(1);

    sink_state_e     state_q, state_d;
    logic [LOGN-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            ready_q, busy_q, full_q, done_q, rd_valid_q;
    logic            accept_s, last_s;

    // ready_q is high exactly while in FILL, so it doubles as the state qualifier.
    assign accept_s = ready_q & strm_i.valid;
    assign last_s   = accept_s & (wr_ptr_q == {LOGN{1'b1}});

    // Next-state and write-pointer logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (last_s) begin
                        state_d     = FULL;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            FULL: begin
                wr_ptr_d = '0;
                if (release_i) begin
                    state_d = start_i ? FILL : IDLE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_ptr_d = '0;
            end
        endcase
    end

    // State, counters and state-decoded status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            frame_cnt_q <= 16'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            ready_q     <= (state_d == FILL);
            busy_q      <= (state_d == FILL);
            full_q      <= (state_d == FULL);
            done_q      <= last_s;
            rd_valid_q  <= rd_req_i;
        end
    end

    fft_sink_ram #(
        .AW (LOGN),
        .DW (2*DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (accept_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (strm_i.data),
        .re_i    (rd_req_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

`ifdef FFT_SINK_PEAK_EN
    // The extra bit keeps |-2^(W-1)| exact.
    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [SINK_DW-1:0] v);
        logic [MAG_W-1:0] x;
        x = {v[SINK_DW-1], v};
        if (x[MAG_W-1]) begin
            return (~x) + {{(MAG_W-1){1'b0}}, 1'b1};
        end else begin
            return x;
        end
    endfunction

    complex_t        word_s;
    logic [MAG_W-1:0] mag_s;
    logic [MAG_W-1:0] peak_mag_q;
    logic [LOGN-1:0]  peak_idx_q;

    assign word_s = complex_t'(strm_i.data);
    assign mag_s  = abs_ext(word_s.re) + abs_ext(word_s.im);

    // Strictly-greater update keeps the lowest index on ties.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            peak_mag_q <= '0;
            peak_idx_q <= '0;
        end else if (accept_s && ((wr_ptr_q == '0) || (mag_s > peak_mag_q))) begin
            peak_mag_q <= mag_s;
            peak_idx_q <= wr_ptr_q;
        end
    end

    assign peak_mag_o = peak_mag_q;
    assign peak_idx_o = peak_idx_q;
`else
    assign peak_mag_o = '0;
    assign peak_idx_o = '0;
`endif

    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign full_o       = full_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign rd_valid_o   = rd_valid_q;

endmodule

// File: doc/fft_frame_sink.md
Name: fft_frame_sink

Overview:
Consumer-side endpoint for the FFT accelerator's natural-order output stream (strm_t valid/data with downstream ready). It drives ready, captures exactly one frame of N = 2^LOGN complex words into a local single-port-write/single-port-read buffer, flags frame completion, and gives the host a random-access read port. It sits between the FFT output and the user-domain register/bus interface. The buffer is held until the host releases it, applying backpressure meanwhile.

Parameters:
DATA_W, 16, width of each Re/Im part; stream word = {Re,Im} = 2*DATA_W bits (equals BITREV_DW).
LOGN, 10, log2 of frame length N; buffer depth and address width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
strm_i  in  strm_t  FFT output stream; .valid, .data = {Re[2*DATA_W-1:DATA_W], Im[DATA_W-1:0]}.
ready_o  out  1  sink ready; a word transfers on strm_i.valid & ready_o.
start_i  in  1  arm capture of one frame (one-cycle pulse).
release_i  in  1  host done with buffer (one-cycle pulse).
busy_o  out  1  capture in progress (FILL state).
full_o  out  1  complete frame held (FULL state).
frame_done_o  out  1  one-cycle pulse on the cycle after the last word is accepted.
frame_cnt_o  out  16  completed frames since reset, wraps at 2^16.
rd_req_i  in  1  host read request.
rd_addr_i  in  LOGN  bin index to read.
rd_valid_o  out  1  rd_data_o valid; asserted exactly 1 cycle after rd_req_i.
rd_data_o  out  2*DATA_W  {Re,Im} of the requested bin.
peak_mag_o  out  DATA_W+1  see Optional Feature.
peak_idx_o  out  LOGN  see Optional Feature.

Behaviour:
- Reset (sync, active-high): state IDLE, wr_ptr=0, frame_cnt_o=0, ready_o=0, busy_o=0, full_o=0, frame_done_o=0, rd_valid_o=0, rd_data_o=0, peak_mag_o=0, peak_idx_o=0. Buffer contents are not cleared.
- FSM states: IDLE, FILL, FULL.
  - IDLE: ready_o=0. start_i -> FILL with wr_ptr=0.
  - FILL: ready_o=1, busy_o=1. Each transfer writes data to buf[wr_ptr] and increments wr_ptr. The transfer at wr_ptr=N-1 moves to FULL, returns wr_ptr to 0, and increments frame_cnt_o. start_i is ignored.
  - FULL: ready_o=0, full_o=1. release_i -> IDLE. release_i together with start_i in the same cycle -> FILL directly.
- frame_done_o pulses in the first FULL cycle.
- ready_o, busy_o and full_o are registered and decoded from state. ready_o deasserts in the cycle after the last word is accepted.
- Words presented while ready_o=0 are not consumed. Upstream must hold them.
- Read port:
  - rd_data_o is registered, 1-cycle latency, in every state.
  - A read and a write to the same address in the same cycle return the old contents.
  - A read in IDLE/FILL returns current buffer contents. Unwritten bins are undefined.
  - rd_valid_o is a registered copy of rd_req_i.
- release_i outside FULL and start_i outside IDLE have no effect.
- Reset mid-FILL abandons the partial frame: no frame_done_o pulse, frame_cnt_o reset to 0.

Optional Feature:
Macro FFT_SINK_PEAK_EN.
- Defined: during FILL, each accepted word computes mag = |Re|+|Im| at DATA_W+1 bits unsigned.
  - Abs of the most negative value is exact, with no saturation thanks to the extra bit.
  - At the first word of a frame the tracker loads mag and index 0.
  - Afterwards it updates only when mag is strictly greater, so the lowest index wins ties.
  - peak_mag_o/peak_idx_o are registered and stable from the frame_done_o cycle until the next frame's first accepted word.
- Undefined: peak_mag_o and peak_idx_o are tied to 0 and no tracking logic is generated. Ports are present in both builds.

Decomposition:
- fft_pkg holds sink_state_e (IDLE/FILL/FULL) and the MAG_W = DATA_W+1 constant. complex_t stays in fft_pkg and is used to unpack strm_i.data.
- strm_t and BITREV_DW stay in user_pkg.
- One sub-module, fft_sink_ram: 1 write port, 1 synchronous read port, depth 2^LOGN, width 2*DATA_W, read-old-data on collision.

Test Plan (LOGN=3, N=8, DATA_W=16):
- Basic capture: reset, start_i, stream 8 words {k, -k} on consecutive cycles.
  - ready_o=1 for 8 accepts; frame_done_o pulses once; full_o=1; frame_cnt_o=1; ready_o=0 afterwards.
  - Reading addr 5 gives rd_data_o=32'h0005_FFFB one cycle after rd_req_i.
- Bubbles/backpressure: valid toggles 1-0-1 and a 9th word is held after the frame ends.
  - Exactly 8 words stored in order; the 9th is not consumed until release_i+start_i.
- Simultaneous release_i+start_i in FULL: next cycle busy_o=1, ready_o=1, wr_ptr=0; the second frame overwrites bin 0; frame_cnt_o reaches 2.
- Reset mid-FILL after 4 words, then start_i and 8 new words: one frame_done_o pulse, frame_cnt_o=1, bins 0-7 hold only new data.
- Stray controls: release_i in IDLE and start_i in FILL cause no state change; frame_cnt_o wraps from 16'hFFFF to 0 (force the counter).
- FFT_SINK_PEAK_EN build: Re/Im inputs with bin 6 = {-32768, 0} and bin 2 = {16384, 16384} give peak_mag_o=32768, peak_idx_o=2 (tie resolved to the lower index). In the non-macro build both outputs read 0.
